exe_stage: RTL

Execute stage of the 5-stage ARM pipeline. It consumes the ID/EXE pipeline register outputs and computes the second operand (immediate rotate, register shift or memory offset). It evaluates the ALU operation and holds the architectural NZCV status register, which feeds back to decode/condition check. It also resolves branch target and taken signal, and applies operand forwarding from the MEM and WB stages. Results go to the EXE/MEM pipeline register.

---
 rtl/exe_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: operand forwarding, operand-2 shifter, ALU, NZCV register, branch target
// Only the status register is clocked; every other output is combinational from the ID/EXE inputs.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] pc,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic        imm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  sr
);

  logic [3:0]  sr_q, sr_d;
  logic [31:0] op_a, op_m, val2;
  logic [63:0] rot_imm_w, ror_w;
  logic [31:0] add_b, res;
  logic [32:0] sum;
  logic        cin, arith, upd, c_n, v_n;
  logic [3:0]  flags;

  always_comb begin
    case (sel_src1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = val_rn;
    endcase
    case (sel_src2)
      2'b01:   op_m = mem_fwd_val;
      2'b10:   op_m = wb_fwd_val;
      default: op_m = val_rm;
    endcase
  end

  // Rotates are done by shifting a doubled word so the low half wraps around.
  assign rot_imm_w = {2{24'b0, shift_operand[7:0]}} >> {shift_operand[11:8], 1'b0};
  assign ror_w     = {op_m, op_m} >> shift_operand[11:7];

  always_comb begin
    val2 = op_m;
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = rot_imm_w[31:0];
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = op_m << shift_operand[11:7];
        2'b01:   val2 = op_m >> shift_operand[11:7];
        2'b10:   val2 = $unsigned($signed(op_m) >>> shift_operand[11:7]);
        default: val2 = ror_w[31:0];
      endcase
    end
  end

  // Subtracts reuse the adder as A + ~Val2 + carry-in, so C comes out as NOT borrow.
  always_comb begin
    res   = '0;
    add_b = val2;
    cin   = 1'b0;
    arith = 1'b0;
    upd   = 1'b1;
    c_n   = sr_q[1];
    v_n   = sr_q[0];
    case (exe_cmd)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = sr_q[1]; end
      4'b0100: begin arith = 1'b1; add_b = ~val2; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; add_b = ~val2; cin = sr_q[1]; end
      4'b0110: res = op_a & val2;
      4'b0111: res = op_a | val2;
      4'b1000: res = op_a ^ val2;
      default: upd = 1'b0;
    endcase
    sum = {1'b0, op_a} + {1'b0, add_b} + {32'b0, cin};
    if (arith) begin
      res = sum[31:0];
      c_n = sum[32];
      v_n = (op_a[31] == add_b[31]) && (res[31] != op_a[31]);
    end
    flags = upd ? {res[31], res == '0, c_n, v_n} : sr_q;
    sr_d  = (s_in && !freeze) ? flags : sr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= 4'b0000;
    else     sr_q <= sr_d;
  end

  assign alu_res      = res;
  assign st_val       = op_m;
  assign wb_en        = wb_en_in;
  assign mem_r_en     = mem_r_en_in;
  assign mem_w_en     = mem_w_en_in;
  assign branch_taken = b_in;
  assign branch_addr  = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign sr           = sr_q;

endmodule
